// File: rtl/f1_lights_seq.sv
// F1 start-light sequencer.
// A trigger starts a fill of N_LIGHTS lamps, one lamp per en tick from bit 0
// upward. All lamps are then held lit for a latched number of en ticks. After
// that they all switch off together and lights_out pulses for one cycle.
// abort cancels the sequence from any state without producing the pulse.
module f1_lights_seq #(
    parameter int N_LIGHTS    = 8,
    parameter int DELAY_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   trigger,
    input  logic                   abort,
    input  logic [DELAY_WIDTH-1:0] delay,
    output logic [N_LIGHTS-1:0]    data_out,
    output logic                   busy,
    output logic                   lights_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [N_LIGHTS-1:0]    data_reg;
    logic [DELAY_WIDTH-1:0] hold_cnt_reg;
    logic [DELAY_WIDTH-1:0] delay_reg;
    logic                   busy_reg;
    logic                   lights_out_reg;

    // Lamp pattern after one more fill step: shift left and light bit 0.
    logic [N_LIGHTS-1:0]    fill_next;
    logic                   all_lit;

    generate
        for (genvar gi = 0; gi < N_LIGHTS; gi++) begin : g_fill
            if (gi == 0) begin : g_lsb
                assign fill_next[gi] = 1'b1;
            end else begin : g_upper
                assign fill_next[gi] = data_reg[gi-1];
            end
        end
    endgenerate

    assign all_lit = &data_reg;

    // Sequencer state machine. Every output comes straight from a register.
    // abort has priority over trigger and en. A cleared en freezes the
    // sequence. The off pulse always self-clears after one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            data_reg       <= '0;
            hold_cnt_reg   <= '0;
            delay_reg      <= '0;
            busy_reg       <= 1'b0;
            lights_out_reg <= 1'b0;
        end else begin
            lights_out_reg <= 1'b0;
            if (abort) begin
                state_reg <= ST_IDLE;
                data_reg  <= '0;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        data_reg <= '0;
                        // en is deliberately ignored on the accepting edge.
                        if (trigger) begin
                            state_reg <= ST_FILL;
                            delay_reg <= delay;
                            busy_reg  <= 1'b1;
                        end
                    end
                    ST_FILL: begin
                        if (en) begin
                            if (all_lit) begin
                                // One full tick with every lamp lit before
                                // the hold count starts.
                                state_reg    <= ST_HOLD;
                                hold_cnt_reg <= delay_reg;
                            end else begin
                                data_reg <= fill_next;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (en) begin
                            if (hold_cnt_reg == '0) begin
                                state_reg      <= ST_IDLE;
                                data_reg       <= '0;
                                busy_reg       <= 1'b0;
                                lights_out_reg <= 1'b1;
                            end else begin
                                // The counter only decrements while nonzero,
                                // so it never wraps, even at the maximum delay.
                                hold_cnt_reg <= hold_cnt_reg - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        data_reg  <= '0;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_reg;
    assign busy       = busy_reg;
    assign lights_out = lights_out_reg;

endmodule

// File: tb/tb_f1_lights_seq.sv
// Testbench for f1_lights_seq. It drives two instances from one stimulus
// stream: the default 8-lamp build and a 4-lamp build with a 3-bit delay.
// A tick-counting reference model predicts both instances every cycle, and
// directed scenarios pin exact edge numbers with literal expectations.
module tb_f1_lights_seq;

    logic       clk;
    logic       rst;
    logic       en;
    logic       trigger;
    logic       abort;
    logic [6:0] delay;

    logic [7:0] d0;
    logic       b0;
    logic       l0;
    logic [3:0] d1;
    logic       b1;
    logic       l1;

    int errors = 0;
    int checks = 0;
    bit done   = 0;

    f1_lights_seq #(.N_LIGHTS(8), .DELAY_WIDTH(7)) u0 (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .abort(abort),
        .delay(delay), .data_out(d0), .busy(b0), .lights_out(l0)
    );

    f1_lights_seq #(.N_LIGHTS(4), .DELAY_WIDTH(3)) u1 (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .abort(abort),
        .delay(delay[2:0]), .data_out(d1), .busy(b1), .lights_out(l1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. A running sequence is described only by the number of
    // en ticks seen since the trigger: lamps lit = min(ticks, N), and the
    // lamps go off on tick N + 2 + latched delay.
    int nl[2]       = '{8, 4};
    int dmask[2]    = '{127, 7};
    int m_active[2];
    int m_ticks[2];
    int m_lat[2];
    int m_pulse[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0;
            m_ticks[i]  = 0;
            m_lat[i]    = 0;
            m_pulse[i]  = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 0;
            if (abort) begin
                m_active[i] = 0;
            end else if (m_active[i] == 0) begin
                if (trigger) begin
                    m_active[i] = 1;
                    m_ticks[i]  = 0;
                    m_lat[i]    = int'(delay) & dmask[i];
                end
            end else if (en) begin
                m_ticks[i]++;
                if (m_ticks[i] == nl[i] + 2 + m_lat[i]) begin
                    m_active[i] = 0;
                    m_pulse[i]  = 1;
                end
            end
        end
    endtask

    function automatic int exp_data(int i);
        int lit;
        if (m_active[i] == 0) return 0;
        lit = (m_ticks[i] < nl[i]) ? m_ticks[i] : nl[i];
        return (1 << lit) - 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Model advance on every rising edge, using the inputs sampled there.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else begin
                model_edge();
                if (m_pulse[0] != 0)
                    $display("seq u0 lamps off at t=%0t latched delay=%0d", $time, m_lat[0]);
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        while (!done) begin
            @(negedge clk);
            if (!done) begin
                chk("u0_data",  int'(d0), exp_data(0));
                chk("u0_busy",  int'(b0), m_active[0]);
                chk("u0_pulse", int'(l0), m_pulse[0]);
                chk("u1_data",  int'(d1), exp_data(1));
                chk("u1_busy",  int'(b1), m_active[1]);
                chk("u1_pulse", int'(l1), m_pulse[1]);
            end
        end
    end

    // One clock edge; inputs are then changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en      = 1'b0;
        trigger = 1'b0;
        abort   = 1'b0;
    endtask

    task automatic settle();
        idle_inputs();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    initial begin
        int n_en;
        int hit;
        rst = 1'b1;
        idle_inputs();
        delay = 7'd0;
        tick();
        tick();
        chk("reset_data", int'(d0), 0);
        chk("reset_busy", int'(b0), 0);
        chk("reset_pulse", int'(l0), 0);
        rst = 1'b0;
        tick();

        // Full sequence, en always high, delay 3.
        $display("scenario: full sequence delay=3");
        delay = 7'd3; en = 1'b1; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("fs_busy_e0", int'(b0), 1);
        chk("fs_data_e0", int'(d0), 0);
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 1)  chk("fs_data_e1", int'(d0), 8'h01);
            if (k == 3)  chk("fs_data_e3", int'(d0), 8'h07);
            if (k == 4)  chk("fs_u1_e4", int'(d1), 4'hF);
            if (k == 8)  chk("fs_data_e8", int'(d0), 8'hFF);
            if (k == 9)  chk("fs_u1_off_e9", int'(l1), 1);
            if (k == 12) chk("fs_busy_e12", int'(b0), 1);
            if (k == 12) chk("fs_data_e12", int'(d0), 8'hFF);
            if (k == 13) chk("fs_off_e13", int'(d0), 0);
            if (k == 13) chk("fs_pulse_e13", int'(l0), 1);
            if (k == 13) chk("fs_busy_e13", int'(b0), 0);
            if (k == 14) chk("fs_pulse_e14", int'(l0), 0);
        end
        settle();

        // Re-trigger during fill with a new delay: ignored.
        $display("scenario: retrigger during fill");
        delay = 7'd3; en = 1'b1; trigger = 1'b1;
        tick();
        for (int k = 1; k <= 13; k++) begin
            trigger = (k <= 4);
            delay   = 7'd100;
            tick();
            if (k == 12) chk("rt_data_e12", int'(d0), 8'hFF);
            if (k == 13) chk("rt_pulse_e13", int'(l0), 1);
        end
        settle();

        // Abort at 0F with trigger high on the same edge.
        $display("scenario: abort at 0F");
        delay = 7'd5; en = 1'b1; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        chk("ab_data_before", int'(d0), 8'h0F);
        abort = 1'b1; trigger = 1'b1;
        tick();
        abort = 1'b0; trigger = 1'b0;
        chk("ab_data", int'(d0), 0);
        chk("ab_busy", int'(b0), 0);
        chk("ab_pulse", int'(l0), 0);
        tick();
        chk("ab_idle_data", int'(d0), 0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("ab_restart_busy", int'(b0), 1);
        tick();
        chk("ab_restart_data", int'(d0), 8'h01);
        settle();

        // Sparse en (every 3rd cycle), delay 0: off on the 10th en edge.
        $display("scenario: sparse en delay=0");
        delay = 7'd0; en = 1'b0; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        n_en = 0;
        hit  = 0;
        for (int c = 1; c <= 60 && hit == 0; c++) begin
            en = (c % 3 == 0);
            tick();
            if (en) n_en++;
            if (en && n_en == 9) chk("sp_full_e9", int'(d0), 8'hFF);
            if (en && n_en == 10) begin
                chk("sp_off_e10", int'(d0), 0);
                chk("sp_pulse_e10", int'(l0), 1);
                hit = 1;
            end
        end
        chk("sp_reached_off", hit, 1);
        en = 1'b0;
        tick();
        chk("sp_pulse_width", int'(l0), 0);
        settle();

        // 4-lamp instance with maximum 3-bit delay 7: off at edge 13.
        $display("scenario: small build delay=7");
        delay = 7'd7; en = 1'b1; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 2)  chk("sm_data_e2", int'(d1), 4'h3);
            if (k == 3)  chk("sm_data_e3", int'(d1), 4'h7);
            if (k == 12) chk("sm_busy_e12", int'(b1), 1);
            if (k == 13) chk("sm_off_e13", int'(d1), 0);
            if (k == 13) chk("sm_pulse_e13", int'(l1), 1);
        end
        settle();

        // Asynchronous reset in the middle of HOLD.
        $display("scenario: reset mid-hold");
        delay = 7'd20; en = 1'b1; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        chk("rs_hold_data", int'(d0), 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rs_async_data", int'(d0), 0);
        chk("rs_async_busy", int'(b0), 0);
        chk("rs_async_pulse", int'(l0), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rs_after_busy", int'(b0), 0);
        chk("rs_after_data", int'(d0), 0);

        // Randomised traffic checked cycle by cycle against the model.
        $display("scenario: random traffic");
        for (int c = 0; c < 6000; c++) begin
            int en_pct;
            en_pct  = (c / 1000) % 2 == 0 ? 90 : 35;
            en      = ($urandom_range(0, 99) < en_pct);
            trigger = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) delay = 7'd127;
            else                           delay = 7'($urandom_range(0, 15));
            tick();
        end
        idle_inputs();
        tick();

        done = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
